// File: rtl/uart_tx_arb.sv
// Multi-channel UART transmitter: round-robin arbiter feeding one serialiser (start, LSB-first data, optional even parity, stop bits).
// Latency: grant in cycle t -> start bit on txd and busy high from cycle t+1; every bit lasts CLK_DIV cycles.
// Backpressure: req_ready pulses one-hot only in IDLE or the last stop-bit cycle; other requesters hold req_valid and wait.
//
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   req_valid     : per-channel request, held while a word is pending
//   req_data      : channel i word in [i*DATA_W +: DATA_W], stable while valid
//   req_ready     : combinational one-hot accept pulse
//   txd           : registered serial output, idles high
//   busy          : registered, high while a frame is on the line
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.

module uart_tx_arb #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_W    = 8,
    parameter int N_CH      = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    output logic                     txd,
    output logic                     busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [PW-1:0] LAST_CH   = PW'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic                bit_end;
    logic                arb_en;
    logic                grant_vld;
    logic                grant;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       rr_next;
    logic [DATA_W-1:0]   grant_word;

    // Round-robin pick. Scanning from the far end down means the last hit
    // written is the nearest valid channel at or above rr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_q) + k) % N_CH]) begin
                grant_vld = 1'b1;
                grant_idx = PW'((int'(rr_q) + k) % N_CH);
            end
        end
    end

    // Arbitration only when the line is free or about to be: IDLE, or the
    // very last cycle of the final stop bit (gives gapless back-to-back frames).
    assign bit_end    = (cnt_q == '0);
    assign arb_en     = (state_q == S_IDLE) ||
                        ((state_q == S_STOP) && bit_end && (bit_q == LAST_STOP));
    assign grant      = grant_vld && arb_en && !rst;
    assign req_ready  = grant ? (N_CH'(1) << grant_idx) : '0;
    assign grant_word = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign rr_next    = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rr_d    = rr_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_LOAD : cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A grant overrides the IDLE/stop-end decision and starts a new frame.
        if (grant) begin
            state_d = S_START;
            cnt_d   = CNT_LOAD;
            shreg_d = grant_word;
            rr_d    = rr_next;
`ifdef UART_TX_PARITY_EN
            // Parity is captured up front because the shift register is consumed.
            par_d   = ^grant_word;
`endif
        end

        // txd/busy are registered, so they are derived from the next state.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rr_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rr_q    <= rr_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
